// File: rtl/win_checker_if.sv
// Connection bundle between the win checker, the game controller and the board storage.
// The checker takes the slave view; the surrounding environment takes the master view.
interface win_checker_if;
   logic       start;
   logic [2:0] drop_row;
   logic [2:0] drop_col;
   logic [1:0] player;
   logic       rd_en;
   logic [2:0] rd_row;
   logic [2:0] rd_col;
   logic [1:0] rd_data;
   logic       busy;
   logic       done;
   logic       win;
   logic [1:0] win_dir;

   modport master (
      output start, drop_row, drop_col, player, rd_data,
      input  rd_en, rd_row, rd_col, busy, done, win, win_dir
   );

   modport slave (
      input  start, drop_row, drop_col, player, rd_data,
      output rd_en, rd_row, rd_col, busy, done, win, win_dir
   );
endinterface

// File: rtl/win_checker.sv
// Connect-Four line detector: walks outward from the last drop in four directions,
// one board probe per cycle, and reports whether a line of WIN_LEN was completed.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; result registers hold the last outcome
// S_SCAN_POS | probing along +direction from the drop point
// S_SCAN_NEG | probing along -direction from the drop point
// S_DONE     | one-cycle result strobe, then back to S_IDLE
module win_checker #(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int WIN_LEN = 4
) (
   input logic          clk,
   input logic          rst_n,
   win_checker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SCAN_POS = 2'd1,
      S_SCAN_NEG = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [3:0] WIN_LEN_C  = 4'(WIN_LEN);
   localparam logic [3:0] LAST_POS_C = 4'(WIN_LEN - 1);
   localparam logic [3:0] ROWS_C     = 4'(ROWS);
   localparam logic [3:0] COLS_C     = 4'(COLS);

   state_t     state_q;
   logic [2:0] row_q;
   logic [2:0] col_q;
   logic [1:0] player_q;
   logic [1:0] dir_q;
   logic [3:0] offset_q;
   logic [3:0] count_q;
   logic       win_q;
   logic [1:0] win_dir_q;

   logic [4:0] off5;
   logic [4:0] row_step;
   logic [4:0] col_step;
   logic [4:0] prb_row;
   logic [4:0] prb_col;
   logic       scanning;
   logic       on_board;
   logic       match;
   logic [3:0] count_inc;

   // Probe coordinate in 5-bit two's complement so off-board cells show up as negative or >= size.
   always_comb begin
      off5     = {1'b0, offset_q};
      row_step = (dir_q == 2'd0) ? 5'd0 : off5;
      case (dir_q)
         2'd0, 2'd2: col_step = off5;
         2'd1:       col_step = 5'd0;
         default:    col_step = -off5;
      endcase
      if (state_q == S_SCAN_NEG) begin
         row_step = -row_step;
         col_step = -col_step;
      end
      prb_row = {2'b00, row_q} + row_step;
      prb_col = {2'b00, col_q} + col_step;
   end

   assign scanning  = (state_q == S_SCAN_POS) || (state_q == S_SCAN_NEG);
   assign on_board  = !prb_row[4] && (prb_row[3:0] < ROWS_C) &&
                      !prb_col[4] && (prb_col[3:0] < COLS_C);
   assign match     = on_board && (bus.rd_data == player_q);
   assign count_inc = count_q + 4'd1;

   assign bus.rd_en   = scanning && on_board;
   assign bus.rd_row  = scanning ? prb_row[2:0] : 3'd0;
   assign bus.rd_col  = scanning ? prb_col[2:0] : 3'd0;
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.win     = win_q;
   assign bus.win_dir = win_dir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         row_q     <= 3'd0;
         col_q     <= 3'd0;
         player_q  <= 2'd0;
         dir_q     <= 2'd0;
         offset_q  <= 4'd0;
         count_q   <= 4'd0;
         win_q     <= 1'b0;
         win_dir_q <= 2'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  row_q     <= bus.drop_row;
                  col_q     <= bus.drop_col;
                  player_q  <= bus.player;
                  win_q     <= 1'b0;
                  win_dir_q <= 2'd0;
                  dir_q     <= 2'd0;
                  offset_q  <= 4'd1;
                  count_q   <= 4'd1;
                  state_q   <= (bus.player == 2'b00) ? S_DONE : S_SCAN_POS;
               end
            end
            S_SCAN_POS: begin
               if (match) begin
                  if (count_inc >= WIN_LEN_C) begin
                     win_q     <= 1'b1;
                     win_dir_q <= dir_q;
                     state_q   <= S_DONE;
                  end else if (offset_q == LAST_POS_C) begin
                     count_q  <= count_inc;
                     offset_q <= 4'd1;
                     state_q  <= S_SCAN_NEG;
                  end else begin
                     count_q  <= count_inc;
                     offset_q <= offset_q + 4'd1;
                  end
               end else begin
                  offset_q <= 4'd1;
                  state_q  <= S_SCAN_NEG;
               end
            end
            S_SCAN_NEG: begin
               if (match) begin
                  if (count_inc >= WIN_LEN_C) begin
                     win_q     <= 1'b1;
                     win_dir_q <= dir_q;
                     state_q   <= S_DONE;
                  end else begin
                     count_q  <= count_inc;
                     offset_q <= offset_q + 4'd1;
                  end
               end else if (dir_q != 2'd3) begin
                  dir_q    <= dir_q + 2'd1;
                  offset_q <= 4'd1;
                  count_q  <= 4'd1;
                  state_q  <= S_SCAN_POS;
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
